clock_reconfig_sequencer: RTL and testbench

CLOCK_RECONFIG_SEQUENCER -- requirements
Module: clock_reconfig_sequencer

---
 rtl/clock_reconfig_sequencer.sv | 209 ++++++++++++++++++++
 tb/tb_clock_reconfig_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_reconfig_sequencer.sv
// Sequences an ICS644 clock-select change: hold video in reset, apply pins, settle, pulse PLL reset, wait for stable lock.
// Optional macro RECONFIG_RETRY_EN: on lock timeout, retry the PLL reset up to MAX_RETRIES times before flagging lock_error.
module clock_reconfig_sequencer #(
    parameter int SETTLE_CYCLES       = 1024,
    parameter int PLL_RESET_CYCLES    = 16,
    parameter int LOCK_STABLE_CYCLES  = 256,
    parameter int LOCK_TIMEOUT_CYCLES = 65535,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       config_changed,
    input  logic [3:0] clock_config_S,
    input  logic       line_doubler,
    input  logic       pll_locked,
    output logic [3:0] ics644_S,
    output logic       line_doubler_out,
    output logic       pll_areset,
    output logic       video_reset,
    output logic       busy,
    output logic       lock_error
);

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_HOLD      = 3'd1,
        ST_APPLY     = 3'd2,
        ST_SETTLE    = 3'd3,
        ST_PLL_RST   = 3'd4,
        ST_WAIT_LOCK = 3'd5,
        ST_RELEASE   = 3'd6
    } state_t;

    // Terminal counts are "last cycle" values since counters start at zero on state entry.
    localparam logic [15:0] SETTLE_LAST  = 16'(SETTLE_CYCLES - 1);
    localparam logic [15:0] PLL_RST_LAST = 16'(PLL_RESET_CYCLES - 1);
    localparam logic [15:0] STABLE_LAST  = 16'(LOCK_STABLE_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [15:0] RETRY_LIMIT  = 16'(MAX_RETRIES);

`ifdef RECONFIG_RETRY_EN
    localparam logic RETRY_EN = 1'b1;
`else
    localparam logic RETRY_EN = 1'b0;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] value);
        logic [15:0] result;
        if (value == 16'hFFFF) begin
            result = value;
        end else begin
            result = value + 16'd1;
        end
        return result;
    endfunction

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] cnt_r;
    logic [15:0] cnt_next_s;
    logic [15:0] stable_r;
    logic [15:0] stable_next_s;
    logic [15:0] retries_r;
    logic [15:0] retries_next_s;
    logic        pending_r;
    logic        pending_next_s;
    logic        lock_error_r;
    logic        lock_error_next_s;
    logic [3:0]  ics644_s_r;
    logic [3:0]  ics644_next_s;
    logic        line_doubler_r;
    logic        line_doubler_next_s;
    logic        pll_areset_r;
    logic        video_reset_r;
    logic        busy_r;
    logic        retry_ok_s;

    assign retry_ok_s = RETRY_EN && (retries_r < RETRY_LIMIT);

    // Next-state, counter, pending and error-flag logic.
    always_comb begin
        state_next_s      = state_r;
        stable_next_s     = 16'd0;
        retries_next_s    = retries_r;
        lock_error_next_s = lock_error_r;
        case (state_r)
            ST_IDLE: begin
                if (config_changed || pending_r) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_HOLD: begin
                retries_next_s = 16'd0;
                state_next_s   = ST_APPLY;
            end
            ST_APPLY: begin
                state_next_s = ST_SETTLE;
            end
            ST_SETTLE: begin
                if (cnt_r >= SETTLE_LAST) begin
                    state_next_s = ST_PLL_RST;
                end else begin
                    state_next_s = ST_SETTLE;
                end
            end
            ST_PLL_RST: begin
                if (cnt_r >= PLL_RST_LAST) begin
                    state_next_s = ST_WAIT_LOCK;
                end else begin
                    state_next_s = ST_PLL_RST;
                end
            end
            ST_WAIT_LOCK: begin
                if (pll_locked) begin
                    stable_next_s = sat_inc(stable_r);
                end else begin
                    stable_next_s = 16'd0;
                end
                // A stable lock completing on the timeout cycle wins.
                if (pll_locked && (stable_r >= STABLE_LAST)) begin
                    lock_error_next_s = 1'b0;
                    state_next_s      = ST_RELEASE;
                end else if (cnt_r >= TIMEOUT_LAST) begin
                    if (retry_ok_s) begin
                        retries_next_s = sat_inc(retries_r);
                        state_next_s   = ST_PLL_RST;
                    end else begin
                        lock_error_next_s = 1'b1;
                        state_next_s      = ST_RELEASE;
                    end
                end else begin
                    state_next_s = ST_WAIT_LOCK;
                end
            end
            ST_RELEASE: begin
                if (pending_r) begin
                    state_next_s = ST_HOLD;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            default: begin
                state_next_s = ST_HOLD;
            end
        endcase

        if (state_next_s != state_r) begin
            cnt_next_s = 16'd0;
        end else begin
            cnt_next_s = sat_inc(cnt_r);
        end

        // Pulses outside IDLE collapse into one pending request, consumed on HOLD entry.
        if ((state_next_s == ST_HOLD) && (state_r != ST_HOLD)) begin
            pending_next_s = 1'b0;
        end else if (config_changed && (state_r != ST_IDLE)) begin
            pending_next_s = 1'b1;
        end else begin
            pending_next_s = pending_r;
        end

        if ((state_next_s == ST_APPLY) && (state_r != ST_APPLY)) begin
            ics644_next_s       = clock_config_S;
            line_doubler_next_s = line_doubler;
        end else begin
            ics644_next_s       = ics644_s_r;
            line_doubler_next_s = line_doubler_r;
        end
    end

    // State, counters and registered outputs decoded from the next state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r        <= ST_HOLD;
            cnt_r          <= 16'd0;
            stable_r       <= 16'd0;
            retries_r      <= 16'd0;
            pending_r      <= 1'b0;
            lock_error_r   <= 1'b0;
            ics644_s_r     <= 4'd0;
            line_doubler_r <= 1'b1;
            pll_areset_r   <= 1'b1;
            video_reset_r  <= 1'b1;
            busy_r         <= 1'b1;
        end else begin
            state_r        <= state_next_s;
            cnt_r          <= cnt_next_s;
            stable_r       <= stable_next_s;
            retries_r      <= retries_next_s;
            pending_r      <= pending_next_s;
            lock_error_r   <= lock_error_next_s;
            ics644_s_r     <= ics644_next_s;
            line_doubler_r <= line_doubler_next_s;
            pll_areset_r   <= (state_next_s == ST_PLL_RST);
            video_reset_r  <= (state_next_s != ST_IDLE) && (state_next_s != ST_RELEASE);
            busy_r         <= (state_next_s != ST_IDLE);
        end
    end

    assign ics644_S         = ics644_s_r;
    assign line_doubler_out = line_doubler_r;
    assign pll_areset       = pll_areset_r;
    assign video_reset      = video_reset_r;
    assign busy             = busy_r;
    assign lock_error       = lock_error_r;

endmodule

// File: tb/tb_clock_reconfig_sequencer.sv
// Bench for clock_reconfig_sequencer: offset-based reference model checked every cycle plus directed literal checks.
module tb_clock_reconfig_sequencer;

    localparam int SET  = 4;
    localparam int PRS  = 2;
    localparam int STB  = 3;
    localparam int TMO  = 20;
    localparam int MR   = 3;
    localparam int PBEG = 2 + SET;
`ifdef RECONFIG_RETRY_EN
    localparam bit RETRY = 1'b1;
`else
    localparam bit RETRY = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       config_changed = 1'b0;
    logic [3:0] clock_config_S = 4'h0;
    logic       line_doubler = 1'b1;
    logic       pll_locked = 1'b0;
    logic [3:0] ics644_S;
    logic       line_doubler_out;
    logic       pll_areset;
    logic       video_reset;
    logic       busy;
    logic       lock_error;

    clock_reconfig_sequencer #(
        .SETTLE_CYCLES(SET), .PLL_RESET_CYCLES(PRS), .LOCK_STABLE_CYCLES(STB),
        .LOCK_TIMEOUT_CYCLES(TMO), .MAX_RETRIES(MR)
    ) dut (
        .clock(clock), .reset(reset), .config_changed(config_changed),
        .clock_config_S(clock_config_S), .line_doubler(line_doubler), .pll_locked(pll_locked),
        .ics644_S(ics644_S), .line_doubler_out(line_doubler_out), .pll_areset(pll_areset),
        .video_reset(video_reset), .busy(busy), .lock_error(lock_error)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: kind 0=idle, 1=in sequence (m_off cycles since HOLD began), 2=release cycle.
    int       m_kind, m_off, m_pbeg, m_run, m_retries;
    bit       m_pend, m_err, m_fresh, m_ld, m_cc, m_lk;
    logic [3:0] m_s;

    task automatic model_reset();
        m_kind = 1; m_off = 0; m_pbeg = PBEG; m_run = 0; m_retries = 0;
        m_pend = 1'b0; m_err = 1'b0; m_fresh = 1'b1; m_s = 4'h0; m_ld = 1'b1;
    endtask

    task automatic model_start();
        m_kind = 1; m_off = 0; m_pbeg = PBEG; m_retries = 0; m_pend = 1'b0;
    endtask

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            model_reset();
        end else begin
            m_cc = config_changed;
            m_lk = pll_locked;
            m_fresh = 1'b0;
            if (m_kind != 0 && m_cc) m_pend = 1'b1;
            if (m_kind == 0) begin
                if (m_cc || m_pend) model_start();
            end else if (m_kind == 2) begin
                if (m_pend) model_start();
                else m_kind = 0;
            end else if (m_off == 0) begin
                m_s = clock_config_S;
                m_ld = line_doubler;
                m_off = 1;
            end else if (m_off < m_pbeg + PRS) begin
                if (m_off == m_pbeg + PRS - 1) m_run = 0;
                m_off++;
            end else begin
                m_run = m_lk ? m_run + 1 : 0;
                if (m_run >= STB) begin
                    m_err = 1'b0;
                    m_kind = 2;
                end else if (m_off - (m_pbeg + PRS) + 1 >= TMO) begin
                    if (RETRY && m_retries < MR) begin
                        m_retries++;
                        m_pbeg = m_off + 1;
                        m_off++;
                    end else begin
                        m_err = 1'b1;
                        m_kind = 2;
                    end
                end else begin
                    m_off++;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            chk("cyc_busy", busy, (m_kind != 0));
            chk("cyc_video_reset", video_reset, (m_kind == 1));
            chk("cyc_pll_areset", pll_areset,
                m_fresh || (m_kind == 1 && m_off >= m_pbeg && m_off < m_pbeg + PRS));
            chk("cyc_ics644_S", ics644_S, m_s);
            chk("cyc_line_doubler_out", line_doubler_out, m_ld);
            chk("cyc_lock_error", lock_error, m_err);
        end
    end

    // mode 0: locked, 1: never locked, 2: 1,1,0,1,1,1 from WAIT_LOCK start, 3: locked plus pulse at offset 3.
    function automatic logic lock_for(input int mode, input int k);
        logic v;
        case (mode)
            1: v = 1'b0;
            2: begin
                case (k - 8)
                    0, 1, 3, 4, 5: v = 1'b1;
                    2: v = 1'b0;
                    default: v = (k > 13);
                endcase
            end
            default: v = 1'b1;
        endcase
        return v;
    endfunction

    task automatic run_seq(input int mode, output int len, output int ar_pulses, output int vr_rises);
        logic ar_prev, vr_prev;
        bit   done;
        len = 0; ar_pulses = 0; vr_rises = 0; ar_prev = 1'b0; vr_prev = 1'b0; done = 1'b0;
        for (int k = 0; k < 400; k++) begin
            pll_locked = lock_for(mode, k);
            config_changed = (mode == 3 && k == 3);
            if (!busy) begin
                done = 1'b1;
                break;
            end
            len++;
            if (pll_areset && !ar_prev) ar_pulses++;
            if (video_reset && !vr_prev) vr_rises++;
            ar_prev = pll_areset;
            vr_prev = video_reset;
            @(negedge clock);
        end
        config_changed = 1'b0;
        if (!done) chk("seq_timeout_busy", busy, 1'b0);
    endtask

    task automatic pulse(input logic [3:0] s, input logic ld);
        clock_config_S = s;
        line_doubler = ld;
        config_changed = 1'b1;
        @(negedge clock);
        config_changed = 1'b0;
    endtask

    int len, arp, vrr;

    initial begin
        reset = 1'b1;
        clock_config_S = 4'hA;
        line_doubler = 1'b1;
        pll_locked = 1'b1;
        repeat (2) @(negedge clock);
        cmp_en = 1'b1;
        chk("rst_busy", busy, 1'b1);
        chk("rst_video_reset", video_reset, 1'b1);
        chk("rst_pll_areset", pll_areset, 1'b1);
        chk("rst_ics644_S", ics644_S, 4'h0);
        chk("rst_line_doubler_out", line_doubler_out, 1'b1);
        chk("rst_lock_error", lock_error, 1'b0);

        // Power-up sequence with current inputs.
        reset = 1'b0;
        run_seq(0, len, arp, vrr);
        chk("boot_busy_len", len, 12);
        chk("boot_ics644_S", ics644_S, 4'hA);
        chk("boot_lock_error", lock_error, 1'b0);

        // Idle request: video_reset next cycle, pins one cycle later.
        pulse(4'h5, 1'b0);
        chk("req_video_reset", video_reset, 1'b1);
        @(negedge clock);
        chk("req_ics644_S", ics644_S, 4'h5);
        chk("req_line_doubler_out", line_doubler_out, 1'b0);
        run_seq(0, len, arp, vrr);
        chk("req_rest_len", len, 11);

        // Request during SETTLE runs a second back-to-back sequence.
        pulse(4'h6, 1'b1);
        run_seq(3, len, arp, vrr);
        chk("pend_busy_len", len, 24);
        chk("pend_video_rises", vrr, 2);

        // Lock glitch restarts the stable count.
        pulse(4'h7, 1'b0);
        run_seq(2, len, arp, vrr);
        chk("glitch_busy_len", len, 15);

        // Lock never arrives.
        pulse(4'h8, 1'b1);
        run_seq(1, len, arp, vrr);
        chk("timeout_busy_len", len, RETRY ? 95 : 29);
        chk("timeout_areset_pulses", arp, RETRY ? 4 : 1);
        chk("timeout_lock_error", lock_error, 1'b1);
        repeat (3) @(negedge clock);
        chk("timeout_err_sticky", lock_error, 1'b1);

        // Successful lock clears the sticky error.
        pulse(4'h9, 1'b0);
        run_seq(0, len, arp, vrr);
        chk("recover_busy_len", len, 12);
        chk("recover_lock_error", lock_error, 1'b0);

        // Asynchronous reset in WAIT_LOCK.
        pll_locked = 1'b0;
        pulse(4'hC, 1'b0);
        repeat (10) @(negedge clock);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 1'b1);
        chk("abort_video_reset", video_reset, 1'b1);
        chk("abort_pll_areset", pll_areset, 1'b1);
        chk("abort_ics644_S", ics644_S, 4'h0);
        chk("abort_line_doubler_out", line_doubler_out, 1'b1);
        chk("abort_lock_error", lock_error, 1'b0);
        @(negedge clock);
        clock_config_S = 4'h3;
        reset = 1'b0;
        run_seq(0, len, arp, vrr);
        chk("abort_rerun_len", len, 12);
        chk("abort_rerun_S", ics644_S, 4'h3);

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
